// File: rtl/ddr3_emif_arbiter.sv
// Two-port arbiter in front of a DDR3 EMIF: port A reads, port B writes.
// Define DDR3_ARB_RR_EN for round-robin; otherwise port A has fixed priority.
module ddr3_emif_arbiter #(
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic         ddr3_emif_clk,
  input  logic         ddr3_emif_rst,
  input  logic         a_read,
  input  logic [21:0]  a_addr,
  input  logic [4:0]   a_burst_count,
  output logic         a_waitrequest,
  output logic [255:0] a_rddata,
  output logic         a_rddata_valid,
  input  logic         b_write,
  input  logic [21:0]  b_addr,
  input  logic [4:0]   b_burst_count,
  input  logic [255:0] b_write_data,
  input  logic [31:0]  b_byte_enable,
  output logic         b_waitrequest,
  input  logic         ddr3_emif_ready,
  input  logic [255:0] ddr3_emif_read_data,
  input  logic         ddr3_emif_rddata_valid,
  output logic         ddr3_emif_read,
  output logic         ddr3_emif_write,
  output logic [21:0]  ddr3_emif_addr,
  output logic [255:0] ddr3_emif_write_data,
  output logic [31:0]  ddr3_emif_byte_enable,
  output logic [4:0]   ddr3_emif_burst_count
);

  typedef enum logic [1:0] {ARB_IDLE, ARB_RD, ARB_WR} state_t;

  state_t      state;
  logic        last_grant_a;
  logic [5:0]  outstanding;
  logic [4:0]  beat_cnt;
  logic [4:0]  burst_lat;

  logic [4:0]  a_burst_eff;
  logic [4:0]  b_burst_eff;
  logic        a_eligible;
  logic        grant_a;
  logic        rd_accept;
  logic        wr_accept;
  logic [6:0]  out_sum;
  logic [6:0]  out_next;

  assign a_burst_eff = (a_burst_count == 5'd0) ? 5'd1 : a_burst_count;
  assign b_burst_eff = (b_burst_count == 5'd0) ? 5'd1 : b_burst_count;

  assign a_eligible = a_read &&
                      (({1'b0, outstanding} + {2'b00, a_burst_eff}) <= 7'(MAX_OUTSTANDING));

`ifdef DDR3_ARB_RR_EN
  assign grant_a = a_eligible && (!b_write || !last_grant_a);
`else
  assign grant_a = a_eligible;
`endif

  assign rd_accept = (state == ARB_RD) && a_read && ddr3_emif_ready;
  assign wr_accept = (state == ARB_WR) && b_write && ddr3_emif_ready;

  // Returns with nothing counted (e.g. in flight across a reset) saturate at zero.
  assign out_sum  = {1'b0, outstanding} + (rd_accept ? {2'b00, a_burst_eff} : 7'd0);
  assign out_next = (ddr3_emif_rddata_valid && (out_sum != 7'd0)) ? out_sum - 7'd1 : out_sum;

  assign a_waitrequest  = !((state == ARB_RD) && ddr3_emif_ready);
  assign b_waitrequest  = !((state == ARB_WR) && ddr3_emif_ready);
  assign a_rddata       = ddr3_emif_read_data;
  assign a_rddata_valid = ddr3_emif_rddata_valid;

  always_ff @(posedge ddr3_emif_clk) begin
    if (ddr3_emif_rst) begin
      state        <= ARB_IDLE;
      last_grant_a <= 1'b0;
      outstanding  <= 6'd0;
      beat_cnt     <= 5'd0;
      burst_lat    <= 5'd0;
    end else begin
      outstanding <= out_next[5:0];
      case (state)
        ARB_IDLE: begin
          if (grant_a) begin
            state        <= ARB_RD;
            last_grant_a <= 1'b1;
          end else if (b_write) begin
            state        <= ARB_WR;
            last_grant_a <= 1'b0;
          end
        end
        ARB_RD: begin
          if (!a_read || ddr3_emif_ready) state <= ARB_IDLE;
        end
        ARB_WR: begin
          // beat_cnt holds beats still owed after the first; zero means burst not started.
          if (wr_accept) begin
            if (beat_cnt == 5'd0) begin
              if (b_burst_eff == 5'd1) begin
                state <= ARB_IDLE;
              end else begin
                beat_cnt  <= b_burst_eff - 5'd1;
                burst_lat <= b_burst_eff;
              end
            end else begin
              beat_cnt <= beat_cnt - 5'd1;
              if (beat_cnt == 5'd1) state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    ddr3_emif_read        = 1'b0;
    ddr3_emif_write       = 1'b0;
    ddr3_emif_addr        = 22'd0;
    ddr3_emif_write_data  = 256'd0;
    ddr3_emif_byte_enable = 32'd0;
    ddr3_emif_burst_count = 5'd0;
    case (state)
      ARB_RD: begin
        ddr3_emif_read        = a_read;
        ddr3_emif_addr        = a_addr;
        ddr3_emif_burst_count = a_burst_eff;
      end
      ARB_WR: begin
        ddr3_emif_write       = b_write;
        ddr3_emif_addr        = b_addr;
        ddr3_emif_write_data  = b_write_data;
        ddr3_emif_byte_enable = b_byte_enable;
        ddr3_emif_burst_count = (beat_cnt == 5'd0) ? b_burst_eff : burst_lat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ddr3_emif_arbiter.sv
// Scoreboard bench for ddr3_emif_arbiter; expected EMIF commands and
// read-return data are queued by the stimulus and checked by a monitor.
module tb_ddr3_emif_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_read;
  logic [21:0]  a_addr;
  logic [4:0]   a_burst_count;
  logic         a_waitrequest;
  logic [255:0] a_rddata;
  logic         a_rddata_valid;
  logic         b_write;
  logic [21:0]  b_addr;
  logic [4:0]   b_burst_count;
  logic [255:0] b_write_data;
  logic [31:0]  b_byte_enable;
  logic         b_waitrequest;
  logic         ready;
  logic [255:0] rd_data;
  logic         rd_valid;
  logic         emif_read;
  logic         emif_write;
  logic [21:0]  emif_addr;
  logic [255:0] emif_wdata;
  logic [31:0]  emif_be;
  logic [4:0]   emif_burst;

  always #5 clk = ~clk;

  ddr3_emif_arbiter #(.MAX_OUTSTANDING(32)) dut (
    .ddr3_emif_clk(clk), .ddr3_emif_rst(rst),
    .a_read(a_read), .a_addr(a_addr), .a_burst_count(a_burst_count),
    .a_waitrequest(a_waitrequest), .a_rddata(a_rddata), .a_rddata_valid(a_rddata_valid),
    .b_write(b_write), .b_addr(b_addr), .b_burst_count(b_burst_count),
    .b_write_data(b_write_data), .b_byte_enable(b_byte_enable), .b_waitrequest(b_waitrequest),
    .ddr3_emif_ready(ready), .ddr3_emif_read_data(rd_data), .ddr3_emif_rddata_valid(rd_valid),
    .ddr3_emif_read(emif_read), .ddr3_emif_write(emif_write), .ddr3_emif_addr(emif_addr),
    .ddr3_emif_write_data(emif_wdata), .ddr3_emif_byte_enable(emif_be),
    .ddr3_emif_burst_count(emif_burst)
  );

  typedef struct {
    bit           wr;
    logic [21:0]  addr;
    logic [4:0]   burst;
    logic [255:0] data;
    logic [31:0]  be;
  } cmd_t;

  cmd_t         exp_q[$];
  logic [255:0] rdq[$];
  int           tests = 0;
  int           fails = 0;
  int           cmd_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] wdata(input logic [21:0] a, input int k);
    return {8{{2'b00, a, 8'(k)}}};
  endfunction

  function automatic cmd_t mk(input bit wr, input logic [21:0] a, input logic [4:0] bc,
                              input logic [255:0] d, input logic [31:0] be);
    cmd_t c;
    c.wr = wr; c.addr = a; c.burst = bc; c.data = d; c.be = be;
    return c;
  endfunction

  cmd_t         mc;
  logic [255:0] mr;
  always @(negedge clk) begin
    if (a_rddata_valid) begin
      if (rdq.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        mr = rdq.pop_front();
        check("rd_data", a_rddata, mr);
      end
    end
    if (!rst && ready && (emif_read || emif_write)) begin
      cmd_cnt++;
      if (exp_q.size() == 0) check("cmd_unexpected", {emif_write, emif_read, emif_addr}, 0);
      else begin
        mc = exp_q.pop_front();
        check("cmd_write", emif_write, mc.wr);
        check("cmd_read", emif_read, !mc.wr);
        check("cmd_addr", emif_addr, mc.addr);
        check("cmd_burst", emif_burst, mc.burst);
        if (mc.wr) begin
          check("cmd_wdata", emif_wdata, mc.data);
          check("cmd_be", emif_be, mc.be);
        end
      end
    end
  end

  task automatic rd_cmd(input logic [21:0] addr, input logic [4:0] bc);
    bit ok = 0;
    exp_q.push_back(mk(0, addr, (bc == 0) ? 5'd1 : bc, 256'd0, 32'd0));
    a_read = 1; a_addr = addr; a_burst_count = bc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!a_waitrequest) begin ok = 1; break; end
    end
    if (!ok) check("rd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_one_cycle", emif_read, 0);
    #1 a_read = 0;
    @(posedge clk); #1;
  endtask

  task automatic ret(input int n, input logic [255:0] base);
    for (int i = 0; i < n; i++) begin
      rd_valid = 1; rd_data = base + 256'(i);
      rdq.push_back(rd_data);
      @(posedge clk); #1;
    end
    rd_valid = 0;
  endtask

  task automatic wr_burst(input logic [21:0] addr, input int n, input logic [4:0] bc,
                          input int stall_beat, input int stall_len, input int gap_beat);
    bit ok;
    logic [4:0] eff = (bc == 0) ? 5'd1 : bc;
    for (int k = 0; k < n; k++)
      exp_q.push_back(mk(1, addr, eff, wdata(addr, k), 32'h0F0F_0000 | 32'(k)));
    b_write = 1; b_addr = addr; b_burst_count = bc;
    for (int k = 0; k < n; k++) begin
      if (k == 1) b_burst_count = 5'd7;  // latched count must survive this
      if (k == stall_beat) begin
        ready = 0;
        for (int j = 0; j < stall_len; j++) begin
          @(negedge clk);
          check("wr_stall_wait", b_waitrequest, 1);
          @(posedge clk); #1;
        end
        ready = 1;
      end
      if (k == gap_beat) begin
        b_write = 0; a_read = 1; a_addr = 22'h3F00; a_burst_count = 5'd1;
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          check("gap_no_write", emif_write, 0);
          check("gap_no_preempt", {emif_read, a_waitrequest}, 2'b01);
          @(posedge clk); #1;
        end
        b_write = 1;
      end
      b_write_data = wdata(addr, k);
      b_byte_enable = 32'h0F0F_0000 | 32'(k);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (!b_waitrequest) begin ok = 1; break; end
      end
      if (!ok) check("wr_accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    b_write = 0; a_read = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int start;
    rst = 1; ready = 1; rd_valid = 0; rd_data = '0;
    a_read = 1; a_addr = 22'h1; a_burst_count = 5'd2;
    b_write = 1; b_addr = 22'h2; b_burst_count = 5'd2; b_write_data = '1; b_byte_enable = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_waitreq", {a_waitrequest, b_waitrequest}, 2'b11);
    check("rst_cmd", {emif_read, emif_write, emif_addr, emif_burst}, 0);
    check("rst_outstanding", dut.outstanding, 0);
    #1 a_read = 0; b_write = 0;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;

    // single 8-beat read and its return
    rd_cmd(22'h000100, 5'd8);
    check("out_after_rd8", dut.outstanding, 8);
    ret(8, 256'h1000);
    @(negedge clk); check("out_after_ret8", dut.outstanding, 0);
    @(posedge clk); #1;

    // 4-beat write, ready low 3 cycles before beat 2
    wr_burst(22'h2000, 4, 5'd4, 1, 3, -1);
    // 3-beat write with b_write gap while port A requests
    wr_burst(22'h3000, 3, 5'd3, -1, 0, 2);

    // zero burst counts behave as 1
    wr_burst(22'h4000, 1, 5'd0, -1, 0, -1);
    rd_cmd(22'h5000, 5'd0);
    check("out_after_bc0", dut.outstanding, 1);
    ret(1, 256'h5000);

    // a_read withdrawn while ready low: no command, counters unchanged
    ready = 0; a_read = 1; a_addr = 22'h5555; a_burst_count = 5'd4;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); check("ready_low_wait", a_waitrequest, 1);
      @(posedge clk); #1;
    end
    a_read = 0;
    repeat (2) @(posedge clk); #1;
    ready = 1;
    repeat (2) @(posedge clk); #1;
    @(negedge clk); check("out_after_withdraw", dut.outstanding, 0);
    @(posedge clk); #1;

    // read accepted in the same cycle as a return beat: 5 + 3 - 1
    rd_cmd(22'h000600, 5'd5);
    check("out_5", dut.outstanding, 5);
    exp_q.push_back(mk(0, 22'h000700, 5'd3, 256'd0, 32'd0));
    a_read = 1; a_addr = 22'h000700; a_burst_count = 5'd3;
    @(posedge clk); #1;
    rd_valid = 1; rd_data = 256'h7777; rdq.push_back(rd_data);
    @(negedge clk); check("same_cycle_accept", a_waitrequest, 0);
    @(posedge clk); #1;
    rd_valid = 0; a_read = 0;
    @(negedge clk); check("out_net_7", dut.outstanding, 7);
    @(posedge clk); #1;
    ret(7, 256'h8000);

    // limit: 4 x 8 fills 32; a further 1-beat read waits for one return
    for (int i = 0; i < 4; i++) rd_cmd(22'h000800 + 22'(i), 5'd8);
    check("out_full", dut.outstanding, 32);
    exp_q.push_back(mk(0, 22'h000900, 5'd1, 256'd0, 32'd0));
    a_read = 1; a_addr = 22'h000900; a_burst_count = 5'd1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk); check("full_hold", a_waitrequest, 1);
      @(posedge clk); #1;
    end
    rd_valid = 1; rd_data = 256'h9000; rdq.push_back(rd_data);
    @(posedge clk); #1 rd_valid = 0;
    begin
      bit ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!a_waitrequest) begin ok = 1; break; end
      end
      check("full_release", ok, 1);
    end
    @(posedge clk); #1 a_read = 0;
    @(negedge clk); check("out_refill", dut.outstanding, 32);
    @(posedge clk); #1;
    ret(32, 256'hA000);
    @(negedge clk); check("out_drained", dut.outstanding, 0);
    @(posedge clk); #1;

    // both ports request continuously; last grant so far was port A
`ifdef DDR3_ARB_RR_EN
    for (int i = 0; i < 4; i++)
      if (i % 2 == 0) exp_q.push_back(mk(1, 22'h0B00, 5'd1, wdata(22'h0B00, 0), 32'h1234_5678));
      else            exp_q.push_back(mk(0, 22'h0A00, 5'd1, 256'd0, 32'd0));
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(0, 22'h0A00, 5'd1, 256'd0, 32'd0));
`endif
    start = cmd_cnt;
    a_read = 1; a_addr = 22'h0A00; a_burst_count = 5'd1;
    b_write = 1; b_addr = 22'h0B00; b_burst_count = 5'd1;
    b_write_data = wdata(22'h0B00, 0); b_byte_enable = 32'h1234_5678;
    for (int i = 0; i < 60 && cmd_cnt < start + 4; i++) begin
      @(posedge clk); #2;
    end
    check("arb_4_grants", cmd_cnt - start, 4);
    a_read = 0; b_write = 0;
    @(posedge clk); #1;
`ifdef DDR3_ARB_RR_EN
    ret(2, 256'hB000);
`else
    ret(4, 256'hB000);
`endif
    @(negedge clk); check("out_after_arb", dut.outstanding, 0);
    @(posedge clk); #1;

    // reset after beat 2 of an 8-beat write, with a read still in flight
    rd_cmd(22'h000C00, 5'd2);
    wr_burst(22'h000D00, 2, 5'd8, -1, 0, -1);
    b_write = 1; b_write_data = wdata(22'h000D00, 2); rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rst_mid_write", emif_write, 0);
    check("rst_mid_idle", {a_waitrequest, b_waitrequest}, 2'b11);
    check("rst_mid_out", dut.outstanding, 0);
    #1 b_write = 0;
    @(posedge clk); #1;
    ret(2, 256'hC000);
    @(negedge clk); check("out_after_stale_ret", dut.outstanding, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cmd_queue_empty", exp_q.size(), 0);
    check("rd_queue_empty", rdq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
